// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory read port, decoder-side valid/ready
// channel and redirect inputs. The fetch unit is the master.
interface fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               jump;
    logic [PC_W-1:0]    jump_target;
    logic               branch;
    logic [PC_W-1:0]    branch_target;
    logic               halted;

    modport master (
        output imem_req, imem_addr, instr, opcode, instr_pc, instr_valid, halted,
        input  imem_valid, imem_rdata, instr_ready, jump, jump_target, branch, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, opcode, instr_pc, instr_valid, halted,
        output imem_valid, imem_rdata, instr_ready, jump, jump_target, branch, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem reads, one-entry output buffer
// with redirect flush. Define FETCH_HALT_EN to stop fetching after opcode 4'hC.
//
// state  | meaning
// IDLE   | first cycle after reset, no request
// REQ    | request issued once the output slot is free
// WAIT   | read outstanding, waiting for imem_valid
// HALT   | HALT instruction loaded, fetch stopped until reset
module fetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    logic [1:0]         state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    instr_pc_q;
    logic [PC_W-1:0]    target;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               drop_q;
    logic               redirect;
    logic               req;
    logic               accept;
    logic               load;
    logic               halt_op;

    assign redirect = (bus.jump | bus.branch) & (state != S_HALT);
    assign target   = bus.jump ? bus.jump_target : bus.branch_target;
    assign req      = (state == S_REQ) & (~valid_q | bus.instr_ready);
    assign accept   = (state == S_WAIT) & bus.imem_valid;
    // a response is thrown away if its request was overtaken by a redirect
    assign load     = accept & ~drop_q & ~redirect;

`ifdef FETCH_HALT_EN
    assign halt_op    = (bus.imem_rdata[INSTR_W-1 -: 4] == 4'hC);
    assign bus.halted = (state == S_HALT);
`else
    assign halt_op    = 1'b0;
    assign bus.halted = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= PC_RST;
            instr_q    <= '0;
            instr_pc_q <= PC_RST;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  state <= S_REQ;
                S_REQ:   if (req) state <= S_WAIT;
                S_WAIT:  if (accept) state <= (load && halt_op) ? S_HALT : S_REQ;
                default: state <= state;
            endcase

            if (accept)
                drop_q <= 1'b0;
            else if (redirect && (state == S_WAIT || req))
                drop_q <= 1'b1;

            if (redirect)
                pc <= target;
            else if (load)
                pc <= pc + PC_W'(1);

            if (redirect)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
            else if (bus.instr_ready)
                valid_q <= 1'b0;

            if (load) begin
                instr_q    <= bus.imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: 4];
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder with programmable latency, a
// stream-level expected-PC model checked every cycle, plus directed cases.
module tb_fetch_unit;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;

    logic clk;
    logic rst;

    fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    int          mem_lat = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic look;
        @(negedge clk);
    endtask

    task automatic wait_valid(input string nm, input int lim);
        int n;
        n = 0;
        look;
        while (!bus.instr_valid && n < lim) begin
            cyc(1); look; n++;
        end
        if (!bus.instr_valid) chk_timeout(nm);
    endtask

    task automatic wait_valid_pc(input string nm, input logic [7:0] pcv, input int lim);
        int n;
        n = 0;
        look;
        while (!(bus.instr_valid && bus.instr_pc == pcv) && n < lim) begin
            cyc(1); look; n++;
        end
        if (!(bus.instr_valid && bus.instr_pc == pcv)) chk_timeout(nm);
    endtask

    task automatic wait_req(input string nm, input int lim);
        int n;
        n = 0;
        look;
        while (!bus.imem_req && n < lim) begin
            cyc(1); look; n++;
        end
        if (!bus.imem_req) chk_timeout(nm);
    endtask

    // instruction memory: answers each request after mem_lat cycles
    logic       m_pend;
    int         m_cnt;
    logic [7:0] m_addr;
    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) m_pend = 1'b0;
            else if (bus.imem_req && !m_pend) begin
                m_pend = 1'b1;
                m_cnt  = mem_lat;
                m_addr = bus.imem_addr;
            end
            @(posedge clk);
            #1;
            bus.imem_valid = 1'b0;
            if (rst) m_pend = 1'b0;
            else if (m_pend) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = mem[m_addr];
                    m_pend = 1'b0;
                end
            end
        end
    end

    // stream model: the presented instruction is always the next one on the
    // architectural path; redirects restart that path at the target
    logic [7:0]  exp_pc;
    logic [7:0]  nxt_pc;
    logic        halt_m;
    logic        hold_prev;
    logic [15:0] held_instr;
    logic [7:0]  held_pc;
    logic        redir_prev;
    logic [7:0]  redir_tgt;
    logic        redir_now;
    int          outst;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc     = 8'h00;
            halt_m     = 1'b0;
            hold_prev  = 1'b0;
            redir_prev = 1'b0;
            outst      = 0;
        end else begin
            if (bus.instr_valid) begin
                chk("m_instr_pc", bus.instr_pc, exp_pc);
                chk("m_instr", bus.instr, mem[bus.instr_pc]);
                chk("m_opcode", bus.opcode, bus.instr[15:12]);
`ifdef FETCH_HALT_EN
                if (bus.opcode == 4'hC) halt_m = 1'b1;
`endif
            end
            chk("m_halted", bus.halted, halt_m);
            if (hold_prev) begin
                chk("m_hold_valid", bus.instr_valid, 1);
                chk("m_hold_instr", bus.instr, held_instr);
                chk("m_hold_pc", bus.instr_pc, held_pc);
            end
            if (redir_prev) begin
                chk("m_redir_flush", bus.instr_valid, 0);
                chk("m_redir_addr", bus.imem_addr, redir_tgt);
            end
            if (bus.instr_valid && !bus.instr_ready) chk("m_stall_req", bus.imem_req, 0);
            if (halt_m) chk("m_halt_req", bus.imem_req, 0);
            if (bus.imem_valid && outst > 0) outst--;
            if (bus.imem_req) begin
                nxt_pc = exp_pc + 8'd1;
                chk("m_outstanding", outst, 0);
                chk("m_req_addr", bus.imem_addr, bus.instr_valid ? nxt_pc : exp_pc);
                outst++;
            end
            redir_now  = (bus.jump || bus.branch) && !halt_m;
            hold_prev  = bus.instr_valid && !bus.instr_ready && !redir_now;
            held_instr = bus.instr;
            held_pc    = bus.instr_pc;
            redir_prev = redir_now;
            redir_tgt  = bus.jump ? bus.jump_target : bus.branch_target;
            if (redir_now) exp_pc = redir_tgt;
            else if (bus.instr_valid && bus.instr_ready) exp_pc = exp_pc + 8'd1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {4'(1 + i % 8), 4'h0, 8'(i)};
        mem[0] = 16'h2123;
        mem[1] = 16'h3456;
        rst               = 1'b1;
        bus.instr_ready   = 1'b0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.branch        = 1'b0;
        bus.branch_target = '0;

        cyc(2); look;
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_halted", bus.halted, 0);

        // first fetches with 1-cycle memory
        cyc(1); rst = 1'b0; bus.instr_ready = 1'b1; look;
        chk("c0_req", bus.imem_req, 0);
        cyc(1); look;
        chk("c1_req", bus.imem_req, 1);
        chk("c1_addr", bus.imem_addr, 0);
        cyc(1); look;
        chk("c2_valid", bus.instr_valid, 0);
        cyc(1); look;
        chk("c3_valid", bus.instr_valid, 1);
        chk("c3_opcode", bus.opcode, 4'h2);
        chk("c3_pc", bus.instr_pc, 0);
        chk("c3_instr", bus.instr, 16'h2123);
        cyc(1); look;
        chk("c4_valid", bus.instr_valid, 0);
        cyc(1); look;
        chk("c5_valid", bus.instr_valid, 1);
        chk("c5_opcode", bus.opcode, 4'h3);
        chk("c5_pc", bus.instr_pc, 1);

        // consumer stall
        cyc(1); bus.instr_ready = 1'b0;
        wait_valid("stall_wait", 20);
        chk("stall_pc", bus.instr_pc, 2);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", bus.imem_req, 0);
            chk("stall_instr", bus.instr, 16'h3002);
            cyc(1); look;
        end
        cyc(1); bus.instr_ready = 1'b1; look;
        chk("ready_req", bus.imem_req, 1);

        // jump while a 3-cycle read is outstanding
        cyc(1); mem_lat = 3;
        wait_req("jw_req", 20);
        cyc(1); bus.jump = 1'b1; bus.jump_target = 8'h40;
        cyc(1); bus.jump = 1'b0;
        wait_req("jw_req2", 20);
        chk("jw_addr", bus.imem_addr, 8'h40);
        cyc(1);
        wait_valid("jw_valid", 20);
        chk("jw_pc", bus.instr_pc, 8'h40);
        chk("jw_instr", bus.instr, 16'h1040);

        // jump and branch together on a held instruction
        cyc(1); bus.instr_ready = 1'b0; mem_lat = 2;
        wait_valid("jb_wait", 20);
        cyc(1);
        bus.jump = 1'b1; bus.jump_target = 8'h10;
        bus.branch = 1'b1; bus.branch_target = 8'h20;
        cyc(1); bus.jump = 1'b0; bus.branch = 1'b0; look;
        chk("jb_flush", bus.instr_valid, 0);
        chk("jb_addr", bus.imem_addr, 8'h10);
        cyc(1); bus.instr_ready = 1'b1;
        wait_valid("jb_valid", 20);
        chk("jb_pc", bus.instr_pc, 8'h10);
        chk("jb_instr", bus.instr, 16'h1010);

        // PC wrap
        cyc(1); mem_lat = 1; bus.jump = 1'b1; bus.jump_target = 8'hFE;
        cyc(1); bus.jump = 1'b0;
        wait_valid_pc("wrap_ff", 8'hFF, 20);
        chk("wrap_instr", bus.instr, 16'h80FF);
        chk("wrap_req", bus.imem_req, 1);
        chk("wrap_addr", bus.imem_addr, 8'h00);
        cyc(1);
        wait_valid("wrap_valid", 20);
        chk("wrap_pc0", bus.instr_pc, 8'h00);
        chk("wrap_instr0", bus.instr, 16'h2123);

        // reset during an outstanding read
        cyc(1); mem_lat = 2;
        wait_req("mr_req", 20);
        cyc(1); rst = 1'b1; #1;
        chk("mr_valid", bus.instr_valid, 0);
        chk("mr_addr", bus.imem_addr, 0);
        chk("mr_req", bus.imem_req, 0);
        chk("mr_instr", bus.instr, 0);
        cyc(2); rst = 1'b0;
        wait_valid("mr_restart", 20);
        chk("mr_pc", bus.instr_pc, 0);

        // opcode C at pc 5
        cyc(1); rst = 1'b1; mem[5] = 16'hC000; mem_lat = 1;
        cyc(2); rst = 1'b0;
        wait_valid_pc("c_wait", 8'h05, 40);
        chk("c_opcode", bus.opcode, 4'hC);
        chk("c_instr", bus.instr, 16'hC000);
`ifdef FETCH_HALT_EN
        chk("halt_flag", bus.halted, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            bus.jump = (i == 1);
            bus.jump_target = 8'h30;
            look;
            chk("halt_req", bus.imem_req, 0);
            chk("halt_addr", bus.imem_addr, 8'h06);
        end
        cyc(1); bus.jump = 1'b0; rst = 1'b1; #1;
        chk("halt_rst", bus.halted, 0);
        cyc(2); rst = 1'b0;
        wait_req("halt_restart", 20);
        chk("halt_restart_addr", bus.imem_addr, 0);
`else
        chk("noh_flag", bus.halted, 0);
        cyc(1);
        wait_valid_pc("noh_next", 8'h06, 20);
        chk("noh_instr", bus.instr, 16'h7006);
`endif

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
